// File: rtl/bidir_dir_sequencer.sv
// Break-before-make sequencer for a 2-channel direction register: released channels drop at once,
// newly driven channels wait out a TURN_CYCLES guard; done pulses when dir_out reaches the target.
module bidir_dir_sequencer #(
  parameter int TURN_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_dir,
  output logic       cmd_ready,
  output logic [1:0] dir_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE = 1'b0, GUARD = 1'b1} state_t;

  localparam logic [7:0] TURN_LOAD = 8'(TURN_CYCLES);

  state_t      state, state_nxt;
  logic [1:0]  target, target_nxt;
  logic [1:0]  dir_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        done_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      target  <= 2'b00;
      dir_out <= 2'b00;
      cnt     <= 8'd0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      target  <= target_nxt;
      dir_out <= dir_nxt;
      cnt     <= cnt_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    dir_nxt    = dir_out;
    cnt_nxt    = cnt;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = 8'd0;
        if (cmd_valid) begin
          target_nxt = cmd_dir;
          if ((cmd_dir & ~dir_out) == 2'b00) begin
            // Only releases (or no change): safe to apply immediately.
            dir_nxt  = cmd_dir;
            done_nxt = 1'b1;
          end else begin
            dir_nxt   = dir_out & cmd_dir;
            cnt_nxt   = TURN_LOAD;
            state_nxt = GUARD;
          end
        end
      end
      GUARD: begin
        // Compare with <= 1 so a corrupted count can never wrap below 1.
        if (cnt <= 8'd1) begin
          dir_nxt   = target;
          done_nxt  = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state == GUARD);
  end

  // A channel may never be made on the same edge another is broken.
  assert property (@(posedge clock) disable iff (reset)
    !((|(dir_out & ~$past(dir_out))) && (|($past(dir_out) & ~dir_out))));

  assert property (@(posedge clock) disable iff (reset) (state == GUARD) |-> (cnt != 8'd0));

endmodule

// File: tb/tb_bidir_dir_sequencer.sv
// Scoreboarded bench for bidir_dir_sequencer with TURN_CYCLES=4 and TURN_CYCLES=1 instances.
module tb_bidir_dir_sequencer;

  typedef struct {
    logic [1:0] d;
    int         e;
  } exp_t;

  logic       clock = 1'b0;
  logic       rst4, v4, rdy4, busy4, done4;
  logic [1:0] d4, dir4;
  logic       rst1, v1, rdy1, busy1, done1;
  logic [1:0] d1, dir1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q4[$];
  exp_t q1[$];
  logic [1:0] m4 = 2'b00;
  logic [1:0] m1 = 2'b00;
  logic [1:0] prev4 = 2'b00;
  logic [1:0] prev1 = 2'b00;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  bidir_dir_sequencer #(.TURN_CYCLES(4)) u4 (
    .clock(clock), .reset(rst4), .cmd_valid(v4), .cmd_dir(d4),
    .cmd_ready(rdy4), .dir_out(dir4), .busy(busy4), .done(done4)
  );

  bidir_dir_sequencer #(.TURN_CYCLES(1)) u1 (
    .clock(clock), .reset(rst1), .cmd_valid(v1), .cmd_dir(d1),
    .cmd_ready(rdy1), .dir_out(dir1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits for cmd_ready, presents one command for one edge and books its expected completion.
  task automatic issue(input int u, input logic [1:0] d);
    int n;
    exp_t x;
    logic [1:0] m;
    n = 0;
    while (((u == 4) ? rdy4 : rdy1) == 1'b0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("cmd_ready_wait", int'(n < 50), 1);
    m = (u == 4) ? m4 : m1;
    x.d = d;
    x.e = cyc + (((d & ~m) != 2'b00) ? u : 0);
    if (u == 4) begin
      q4.push_back(x); m4 = d; v4 = 1'b1; d4 = d;
    end else begin
      q1.push_back(x); m1 = d; v1 = 1'b1; d1 = d;
    end
    @(negedge clock);
    v4 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic wait_idle4();
    int n;
    n = 0;
    while (busy4 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("idle4_wait", int'(n < 50), 1);
  endtask

  always @(negedge clock) begin
    if (!rst4) begin
      if (dir4 != prev4)
        chk("u4_break_before_make",
            int'((|(dir4 & ~prev4)) && (|(prev4 & ~dir4))), 0);
      if (done4) begin
        if (q4.size() == 0) chk("u4_unexpected_done", 1, 0);
        else begin
          exp_t x;
          x = q4.pop_front();
          chk("u4_done_dir", int'(dir4), int'(x.d));
          chk("u4_done_edge", cyc - 1, x.e);
        end
      end
    end
    prev4 = dir4;
  end

  always @(negedge clock) begin
    if (!rst1) begin
      if (dir1 != prev1)
        chk("u1_break_before_make",
            int'((|(dir1 & ~prev1)) && (|(prev1 & ~dir1))), 0);
      if (done1) begin
        if (q1.size() == 0) chk("u1_unexpected_done", 1, 0);
        else begin
          exp_t x;
          x = q1.pop_front();
          chk("u1_done_dir", int'(dir1), int'(x.d));
          chk("u1_done_edge", cyc - 1, x.e);
        end
      end
    end
    prev1 = dir1;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst4 = 1'b1; v4 = 1'b0; d4 = 2'b00;
    rst1 = 1'b1; v1 = 1'b0; d1 = 2'b00;
    repeat (3) @(negedge clock);
    rst4 = 1'b0;
    chk("rst_dir", int'(dir4), 0);
    chk("rst_busy", int'(busy4), 0);
    chk("rst_ready", int'(rdy4), 1);
    chk("rst_done", int'(done4), 0);

    // 00 -> 01: four guard cycles with dir held at 00, completion on the fourth edge after accept.
    issue(4, 2'b01);
    for (int i = 0; i < 4; i++) begin
      chk("g1_busy", int'(busy4), 1);
      chk("g1_ready", int'(rdy4), 0);
      chk("g1_dir_held", int'(dir4), 0);
      @(negedge clock);
    end
    chk("g1_dir_final", int'(dir4), 1);
    chk("g1_busy_clear", int'(busy4), 0);

    // Equal command: immediate done, no change.
    issue(4, 2'b01);
    chk("same_dir", int'(dir4), 1);
    chk("same_busy", int'(busy4), 0);

    // Pure release: immediate.
    issue(4, 2'b00);
    chk("rel_dir", int'(dir4), 0);
    chk("rel_busy", int'(busy4), 0);

    // 01 -> 10: 01 drops at accept, 10 appears after the guard.
    issue(4, 2'b01);
    wait_idle4();
    issue(4, 2'b10);
    chk("swap_dir_break", int'(dir4), 0);
    chk("swap_busy", int'(busy4), 1);
    wait_idle4();
    chk("swap_dir_final", int'(dir4), 2);

    // Command during GUARD is ignored.
    issue(4, 2'b01);
    v4 = 1'b1; d4 = 2'b11;
    @(negedge clock);
    v4 = 1'b0;
    wait_idle4();
    chk("ignore_dir_final", int'(dir4), 1);
    @(negedge clock);
    chk("ignore_no_extra_done", int'(done4), 0);

    // Reset on the second guard cycle aborts without done.
    issue(4, 2'b10);
    @(negedge clock);
    rst4 = 1'b1;
    q4.delete();
    m4 = 2'b00;
    @(negedge clock);
    rst4 = 1'b0;
    chk("abort_dir", int'(dir4), 0);
    chk("abort_busy", int'(busy4), 0);
    chk("abort_ready", int'(rdy4), 1);
    chk("abort_done", int'(done4), 0);
    repeat (6) @(negedge clock);
    chk("abort_still_no_done", int'(done4), 0);

    // TURN_CYCLES=1: single guard cycle, then back-to-back accept in the done cycle.
    rst1 = 1'b0;
    chk("u1_rst_ready", int'(rdy1), 1);
    issue(1, 2'b11);
    chk("u1_guard_busy", int'(busy1), 1);
    chk("u1_guard_dir", int'(dir1), 0);
    @(negedge clock);
    chk("u1_done_first", int'(done1), 1);
    chk("u1_dir_first", int'(dir1), 3);
    chk("u1_ready_in_done", int'(rdy1), 1);
    issue(1, 2'b11);
    chk("u1_done_again", int'(done1), 1);
    chk("u1_busy_b2b", int'(busy1), 0);
    @(negedge clock);
    chk("u1_done_one_cycle", int'(done1), 0);

    repeat (3) @(negedge clock);
    chk("u4_queue_drained", q4.size(), 0);
    chk("u1_queue_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
